// File: rtl/controller_me_param.sv
// Motion-estimation controller, parametrised full-search sequencer.
// Loads the CPR/SPR arrays, then walks a 2*SEARCH_RANGE square of candidates
// in snake order (down even columns, up odd columns), raising valid once per
// candidate while the SAD tree output belongs to (mv_x, mv_y).
// Optional build macro ME_EARLY_TERM_EN adds the early_stop input, which ends
// the scan at the current valid candidate.
module controller_me_param #(
  parameter int MACRO_DIM    = 16,
  parameter int SEARCH_RANGE = 16,
  parameter int PIPE_DEPTH   = 4,
  parameter int SHIFT_LAT    = 1,
  parameter int CNT_W        = $clog2(MACRO_DIM + PIPE_DEPTH + 2*SEARCH_RANGE + SHIFT_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
`ifdef ME_EARLY_TERM_EN
  input  logic             early_stop,
`endif
  output logic             ready,
  output logic             busy,
  output logic             en_cpr,
  output logic             en_spr,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [CNT_W-1:0] mv_x,
  output logic [CNT_W-1:0] mv_y,
  output logic             done
);

  localparam int N = 2 * SEARCH_RANGE;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(MACRO_DIM + PIPE_DEPTH - 1);
  // WAIT holds SHIFT_LAT-1 cycles; the constant is only used when SHIFT_LAT > 1
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((SHIFT_LAT > 1) ? SHIFT_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, EVAL, SHIFT_V, SHIFT_H, WAIT, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             row_end;
  logic             stop_now;

  assign mv_x = col;
  assign mv_y = row;

  // The column parity decides whether the snake is heading down or up
  always_comb begin
    row_end = col[0] ? (row == '0) : (row == LAST_IDX);
`ifdef ME_EARLY_TERM_EN
    stop_now = early_stop;
`else
    stop_now = 1'b0;
`endif
  end

  // Sequencer: state, counters and every registered output in one process
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      col    <= '0;
      row    <= '0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      en_cpr <= 1'b0;
      en_spr <= 1'b0;
      sel    <= 2'd0;
      valid  <= 1'b0;
      done   <= 1'b0;
    end else begin
      // Outputs describe the state being entered; default is a quiet busy cycle
      ready  <= 1'b0;
      busy   <= 1'b1;
      en_cpr <= 1'b0;
      en_spr <= 1'b0;
      sel    <= 2'd0;
      valid  <= 1'b0;
      done   <= 1'b0;
      if (abort) begin
        // Cancel from anywhere (also overrides start while idle)
        state <= IDLE;
        cnt   <= '0;
        col   <= '0;
        row   <= '0;
        ready <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state  <= LOAD;
              cnt    <= '0;
              en_cpr <= 1'b1;
              en_spr <= 1'b1;
            end else begin
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
          LOAD: begin
            if (cnt == LOAD_LAST) begin
              state <= EVAL;
              cnt   <= '0;
              valid <= 1'b1;
            end else begin
              cnt    <= cnt + ONE;
              en_cpr <= 1'b1;
              en_spr <= 1'b1;
            end
          end
          EVAL: begin
            if (stop_now || (row_end && col == LAST_IDX)) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (row_end) begin
              state  <= SHIFT_H;
              en_spr <= 1'b1;
              sel    <= 2'd2;
            end else begin
              state  <= SHIFT_V;
              en_spr <= 1'b1;
              sel    <= {1'b0, col[0]};
            end
          end
          SHIFT_V, SHIFT_H: begin
            if (state == SHIFT_V) begin
              row <= col[0] ? row - ONE : row + ONE;
            end else begin
              col <= col + ONE;
            end
            cnt <= '0;
            if (SHIFT_LAT > 1) begin
              state <= WAIT;
            end else begin
              state <= EVAL;
              valid <= 1'b1;
            end
          end
          WAIT: begin
            if (cnt == WAIT_LAST) begin
              state <= EVAL;
              cnt   <= '0;
              valid <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DONE: begin
            state <= IDLE;
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controller_me_param.sv
// Bench for controller_me_param: two instances (SHIFT_LAT 1 and 3) with a
// 4x4 candidate window, driven from per-cycle vector tables built by a
// position/time model of the snake scan, plus directed reset/abort cases.
module tb_controller_me_param;

  localparam int MD   = 4;
  localparam int SR   = 2;
  localparam int PD   = 2;
  localparam int N    = 2 * SR;
  localparam int NN   = N * N;
  localparam int L    = MD + PD;
  localparam int CW_A = $clog2(MD + PD + 2*SR + 1 + 1);
  localparam int CW_B = $clog2(MD + PD + 2*SR + 3 + 1);

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       en_cpr;
    logic       en_spr;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] mv_x;
    logic [7:0] mv_y;
    logic       done;
  } out_t;

  typedef struct packed {
    logic start;
    logic abort;
    logic early;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0;
`ifdef ME_EARLY_TERM_EN
  logic early_a = 1'b0, early_b = 1'b0;
`endif
  logic ready_a, busy_a, en_cpr_a, en_spr_a, valid_a, done_a;
  logic ready_b, busy_b, en_cpr_b, en_spr_b, valid_b, done_b;
  logic [1:0] sel_a, sel_b;
  logic [CW_A-1:0] mv_x_a, mv_y_a;
  logic [CW_B-1:0] mv_x_b, mv_y_b;

  int errors = 0;
  int checks = 0;
  int n_valid, n_sel2, done_t;
  vec_t vecs [0:127];

  always #5 clk = ~clk;

  controller_me_param #(.MACRO_DIM(MD), .SEARCH_RANGE(SR), .PIPE_DEPTH(PD), .SHIFT_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
`ifdef ME_EARLY_TERM_EN
    .early_stop(early_a),
`endif
    .ready(ready_a), .busy(busy_a), .en_cpr(en_cpr_a), .en_spr(en_spr_a), .sel(sel_a),
    .valid(valid_a), .mv_x(mv_x_a), .mv_y(mv_y_a), .done(done_a));

  controller_me_param #(.MACRO_DIM(MD), .SEARCH_RANGE(SR), .PIPE_DEPTH(PD), .SHIFT_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
`ifdef ME_EARLY_TERM_EN
    .early_stop(early_b),
`endif
    .ready(ready_b), .busy(busy_b), .en_cpr(en_cpr_b), .en_spr(en_spr_b), .sel(sel_b),
    .valid(valid_b), .mv_x(mv_x_b), .mv_y(mv_y_b), .done(done_b));

  function automatic out_t get_out(input int which);
    out_t o;
    if (which == 0) begin
      o = '{ready_a, busy_a, en_cpr_a, en_spr_a, sel_a, valid_a, 8'(mv_x_a), 8'(mv_y_a), done_a};
    end else begin
      o = '{ready_b, busy_b, en_cpr_b, en_spr_b, sel_b, valid_b, 8'(mv_x_b), 8'(mv_y_b), done_b};
    end
    return o;
  endfunction

  // Cycle (start sampled at end of cycle 0) at which candidate k is valid
  function automatic int valid_cycle(input int sl, input int k);
    return L + 1 + k * (sl + 1);
  endfunction

  // Expected outputs in cycle t: load, then per candidate one EVAL cycle
  // followed by sl shift/wait cycles; done one cycle after the last EVAL.
  function automatic out_t model(input int sl, input int t, input int abort_t, input int end_k);
    out_t o;
    int u, k, ph, c, r;
    o = '0;
    o.ready = 1'b1;
    if (t == 0 || (abort_t >= 0 && t > abort_t)) return o;
    if (t <= L) begin
      o.ready = 1'b0; o.busy = 1'b1; o.en_cpr = 1'b1; o.en_spr = 1'b1;
      return o;
    end
    u  = t - L - 1;
    k  = u / (sl + 1);
    ph = u % (sl + 1);
    if (k <= end_k && ph == 0) begin
      c = k / N;
      r = k % N;
      o.ready = 1'b0; o.busy = 1'b1; o.valid = 1'b1;
      o.mv_x = 8'(c);
      o.mv_y = 8'((c % 2 == 0) ? r : N - 1 - r);
    end else if (k == end_k && ph == 1) begin
      o.ready = 1'b0; o.busy = 1'b1; o.done = 1'b1;
    end else if (k < end_k) begin
      o.ready = 1'b0; o.busy = 1'b1;
      if (ph == 1) begin
        o.en_spr = 1'b1;
        if ((k + 1) / N != k / N) o.sel = 2'd2;
        else o.sel = ((k / N) % 2 == 1) ? 2'd1 : 2'd0;
      end
    end
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy%b bsy%b cpr%b spr%b sel%0d vld%b mv(%0d,%0d) done%b, want rdy%b bsy%b cpr%b spr%b sel%0d vld%b mv(%0d,%0d) done%b",
               name, act.ready, act.busy, act.en_cpr, act.en_spr, act.sel, act.valid, act.mv_x, act.mv_y, act.done,
               exp.ready, exp.busy, exp.en_cpr, exp.en_spr, exp.sel, exp.valid, exp.mv_x, exp.mv_y, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Fill the vector table for one search on instance which
  task automatic build(input int sl, input int abort_t, input int early_k, input bit noise, output int n);
    int end_k, dc, lim;
    end_k = (early_k >= 0) ? early_k : NN - 1;
    dc    = valid_cycle(sl, end_k) + 1;
    lim   = (abort_t >= 0 && abort_t < dc) ? abort_t : dc;
    n     = lim + 3;
    for (int t = 0; t < n; t++) begin
      vecs[t].exp   = model(sl, t, abort_t, end_k);
      vecs[t].start = (t == 0) || (noise && t >= 1 && t <= lim && ($urandom % 4 == 0));
      vecs[t].abort = (t == abort_t);
      vecs[t].early = (early_k >= 0 && t == valid_cycle(sl, early_k)) ||
                      (noise && !vecs[t].exp.valid && ($urandom % 3 == 0));
    end
  endtask

  task automatic apply(input int which, input int n, input string name);
    out_t act;
    n_valid = 0; n_sel2 = 0; done_t = -1;
    for (int t = 0; t < n; t++) begin
      if (which == 0) begin
        start_a = vecs[t].start; abort_a = vecs[t].abort;
`ifdef ME_EARLY_TERM_EN
        early_a = vecs[t].early;
`endif
      end else begin
        start_b = vecs[t].start; abort_b = vecs[t].abort;
`ifdef ME_EARLY_TERM_EN
        early_b = vecs[t].early;
`endif
      end
      act = get_out(which);
      if (act.valid) n_valid++;
      if (act.sel == 2'd2) n_sel2++;
      if (act.done && done_t < 0) done_t = t;
      // Vector outputs are only defined while valid or idle
      if (!(vecs[t].exp.valid || vecs[t].exp.ready)) begin
        act.mv_x = vecs[t].exp.mv_x;
        act.mv_y = vecs[t].exp.mv_y;
      end
      check_out($sformatf("%s t=%0d", name, t), act, vecs[t].exp);
      @(posedge clk); #1;
    end
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
`ifdef ME_EARLY_TERM_EN
    early_a = 1'b0; early_b = 1'b0;
`endif
  endtask

  out_t idle_o;
  int n, any_done, sl, ab, ek, which;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_o = '0;
    idle_o.ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_out("reset_a", get_out(0), idle_o);
    check_out("reset_b", get_out(1), idle_o);

    // Reset held 3 cycles in the middle of LOAD
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_out("midload_reset", get_out(0), idle_o);
    any_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_a || !ready_a) any_done = 1;
    end
    check_int("midload_reset_quiet", any_done, 0);

    // Full scan, SHIFT_LAT=1
    build(1, -1, -1, 1'b0, n);
    apply(0, n, "scan_sl1");
    check_int("scan_sl1_valids", n_valid, 16);
    check_int("scan_sl1_sel2", n_sel2, 3);
    check_int("scan_sl1_done_t", done_t, 38);

    // Full scan, SHIFT_LAT=3: L + NN + (NN-1)*3 busy cycles before DONE
    build(3, -1, -1, 1'b0, n);
    apply(1, n, "scan_sl3");
    check_int("scan_sl3_valids", n_valid, 16);
    check_int("scan_sl3_done_t", done_t, L + NN + (NN - 1) * 3 + 1);

    // Abort on the 5th valid, then a clean rescan
    build(1, valid_cycle(1, 4), -1, 1'b0, n);
    apply(0, n, "abort5");
    check_int("abort5_valids", n_valid, 5);
    check_int("abort5_no_done", done_t, -1);
    build(1, -1, -1, 1'b0, n);
    apply(0, n, "rescan");
    check_int("rescan_valids", n_valid, 16);

    // start with abort while idle
    build(1, 0, -1, 1'b0, n);
    apply(0, n, "start_abort_idle");
    check_int("start_abort_idle_valids", n_valid, 0);

`ifdef ME_EARLY_TERM_EN
    // early_stop on the 3rd valid
    build(1, -1, 2, 1'b0, n);
    apply(0, n, "early3");
    check_int("early3_valids", n_valid, 3);
    check_int("early3_done_t", done_t, valid_cycle(1, 2) + 1);
`endif

    // Randomised searches: instance, abort point, early stop and input noise
    for (int it = 0; it < 20; it++) begin
      which = $urandom % 2;
      sl    = (which == 0) ? 1 : 3;
      ek    = -1;
`ifdef ME_EARLY_TERM_EN
      if ($urandom % 2 == 0) ek = $urandom_range(0, NN - 1);
`endif
      ab = ($urandom % 3 == 0) ? -1
           : $urandom_range(0, valid_cycle(sl, (ek >= 0) ? ek : NN - 1) + 1);
      build(sl, ab, ek, 1'b1, n);
      apply(which, n, $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
